// File: rtl/key_debounce_repeat.sv
// Debounces N active-low push-buttons on a shared tick enable and emits
// single-cycle press, release and auto-repeat pulses, all on i_clk.
module key_debounce_repeat #(
  parameter int N_KEYS             = 6,
  parameter int F_CLK              = 50000000,
  parameter int F_TICK             = 1000,
  parameter int DEBOUNCE_TICKS     = 20,
  parameter int REPEAT_DELAY_TICKS = 500,
  parameter int REPEAT_RATE_TICKS  = 100
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [N_KEYS-1:0] i_key,
  output logic [N_KEYS-1:0] o_key_state,
  output logic [N_KEYS-1:0] o_press,
  output logic [N_KEYS-1:0] o_release,
  output logic [N_KEYS-1:0] o_repeat,
  output logic              o_tick
);

  localparam int TICK_DIV = F_CLK / F_TICK;
  localparam int TW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
  localparam int HW = (REPEAT_DELAY_TICKS < 1) ? 1 : $clog2(REPEAT_DELAY_TICKS + 1);

  localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST    = DW'(DEBOUNCE_TICKS - 1);
  localparam logic [HW-1:0] HOLD_LAST   = HW'(REPEAT_DELAY_TICKS - 1);
  localparam logic [HW-1:0] HOLD_RELOAD = HW'(REPEAT_DELAY_TICKS - REPEAT_RATE_TICKS);
  localparam bit            REPEAT_EN   = (REPEAT_RATE_TICKS != 0);

  if (TICK_DIV < 2) begin : g_chk_div
    $error("key_debounce_repeat: TICK_DIV must be >= 2");
  end
  if (DEBOUNCE_TICKS < 1) begin : g_chk_deb
    $error("key_debounce_repeat: DEBOUNCE_TICKS must be >= 1");
  end
  if (REPEAT_RATE_TICKS > REPEAT_DELAY_TICKS) begin : g_chk_rep
    $error("key_debounce_repeat: REPEAT_RATE_TICKS must be <= REPEAT_DELAY_TICKS");
  end

  logic [N_KEYS-1:0] sync1_q, sync2_q;
  logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
  logic              tick_q, tick_d;
  logic [DW-1:0]     deb_q  [N_KEYS];
  logic [DW-1:0]     deb_d  [N_KEYS];
  logic [HW-1:0]     hold_q [N_KEYS];
  logic [HW-1:0]     hold_d [N_KEYS];
  logic [N_KEYS-1:0] state_q, state_d;
  logic [N_KEYS-1:0] press_q, press_d;
  logic [N_KEYS-1:0] release_q, release_d;
  logic [N_KEYS-1:0] repeat_q, repeat_d;

  always_comb begin
    tick_d     = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick_d ? '0 : tick_cnt_q + 1'b1;
    state_d    = state_q;
    press_d    = '0;
    release_d  = '0;
    repeat_d   = '0;
    for (int k = 0; k < N_KEYS; k++) begin
      deb_d[k]  = deb_q[k];
      hold_d[k] = hold_q[k];

      if (sync2_q[k] == state_q[k]) begin
        deb_d[k] = '0;
      end else if (tick_q) begin
        if (deb_q[k] == DEB_LAST) begin
          state_d[k]   = sync2_q[k];
          press_d[k]   = ~sync2_q[k];
          release_d[k] = sync2_q[k];
          deb_d[k]     = '0;
        end else begin
          deb_d[k] = deb_q[k] + 1'b1;
        end
      end

      // Hold count only runs while the accepted level stays pressed.
      if (state_q[k] || (state_d[k] != state_q[k])) begin
        hold_d[k] = '0;
      end else if (tick_q) begin
        if (hold_q[k] == HOLD_LAST) begin
          if (REPEAT_EN) begin
            repeat_d[k] = 1'b1;
            hold_d[k]   = HOLD_RELOAD;
          end
        end else begin
          hold_d[k] = hold_q[k] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      tick_cnt_q <= '0;
      tick_q     <= 1'b0;
      state_q    <= '1;
      press_q    <= '0;
      release_q  <= '0;
      repeat_q   <= '0;
      for (int k = 0; k < N_KEYS; k++) begin
        deb_q[k]  <= '0;
        hold_q[k] <= '0;
      end
    end else begin
      sync1_q    <= i_key;
      sync2_q    <= sync1_q;
      tick_cnt_q <= tick_cnt_d;
      tick_q     <= tick_d;
      state_q    <= state_d;
      press_q    <= press_d;
      release_q  <= release_d;
      repeat_q   <= repeat_d;
      for (int k = 0; k < N_KEYS; k++) begin
        deb_q[k]  <= deb_d[k];
        hold_q[k] <= hold_d[k];
      end
    end
  end

  assign o_key_state = state_q;
  assign o_press     = press_q;
  assign o_release   = release_q;
  assign o_repeat    = repeat_q;
  assign o_tick      = tick_q;

endmodule

// File: tb/tb_key_debounce_repeat.sv
// Directed bench for key_debounce_repeat: expected pulse events are queued with
// their exact cycle when keys are driven, then matched as the DUT emits them.
module tb_key_debounce_repeat;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic [5:0] i_key = 6'h3F;
  logic [5:0] o_key_state, o_press, o_release, o_repeat;
  logic       o_tick;

  always #5 i_clk = ~i_clk;

  key_debounce_repeat #(
    .N_KEYS(6), .F_CLK(1000), .F_TICK(100),
    .DEBOUNCE_TICKS(3), .REPEAT_DELAY_TICKS(5), .REPEAT_RATE_TICKS(2)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_key(i_key),
    .o_key_state(o_key_state), .o_press(o_press), .o_release(o_release),
    .o_repeat(o_repeat), .o_tick(o_tick)
  );

  typedef struct {
    string      tag;
    logic [5:0] prs;
    logic [5:0] rel;
    logic [5:0] rpt;
    int         at;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          now = 0;
  int          t0 = 0;
  logic [23:0] watch;

  task automatic step();
    @(posedge i_clk);
    #1;
    now++;
  endtask

  // First tick-enable cycle at or after step s; ticks fall every 10 cycles from t0.
  function automatic int next_tick(int s);
    if (s <= t0) return t0;
    return t0 + ((s - t0 + 9) / 10) * 10;
  endfunction

  // Input driven at step t: visible after the 2-flop sync, accepted one cycle after the third tick.
  function automatic int accept_at(int t);
    return next_tick(t + 2) + 21;
  endfunction

  task automatic check_bits(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(string tag, logic [5:0] p, logic [5:0] r, logic [5:0] rp, int at);
    exp_t e;
    e.tag = tag; e.prs = p; e.rel = r; e.rpt = rp; e.at = at;
    sb.push_back(e);
  endtask

  task automatic expect_next();
    exp_t e;
    bit   seen;
    int   budget;
    seen = 1'b0;
    e = sb.pop_front();
    budget = e.at - now + 3;
    for (int i = 0; i < budget; i++) begin
      step();
      if ((o_press | o_release | o_repeat) != 6'h00) begin
        seen = 1'b1;
        break;
      end
    end
    check_bits({e.tag, "_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check_bits({e.tag, "_pulse"}, {o_press, o_release, o_repeat}, {e.prs, e.rel, e.rpt});
      check_bits({e.tag, "_cycle"}, now, e.at);
      step();
      check_bits({e.tag, "_width"}, {o_press, o_release, o_repeat}, 32'd0);
    end
  endtask

  task automatic drain();
    while (sb.size() != 0) expect_next();
  endtask

  task automatic run_watch(int n);
    repeat (n) begin
      step();
      watch |= {o_press, o_release, o_repeat, ~o_key_state};
    end
  endtask

  initial begin
    int first, nt, p, r;
    bit bad;

    // 1: reset values and tick cadence
    repeat (3) step();
    check_bits("rst_state", o_key_state, 32'h3F);
    check_bits("rst_pulses", {o_press, o_release, o_repeat}, 32'd0);
    check_bits("rst_tick", o_tick, 32'd0);
    i_rst = 1'b0;
    t0 = now + 10;
    first = -1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (o_tick) begin
        first = now;
        break;
      end
    end
    check_bits("tick_first", first, t0);
    nt = 0;
    bad = 1'b0;
    repeat (30) begin
      step();
      if (o_tick) begin
        nt++;
        if ((now - t0) % 10 != 0) bad = 1'b1;
      end
    end
    check_bits("tick_count", nt, 32'd3);
    check_bits("tick_phase", 32'(bad), 32'd0);

    // 2: bounces shorter than the debounce window are rejected
    watch = '0;
    i_key[0] = 1'b0; run_watch(15);
    i_key[0] = 1'b1; run_watch(5);
    i_key[0] = 1'b0; run_watch(15);
    i_key[0] = 1'b1; run_watch(40);
    check_bits("bounce_reject", watch, 32'd0);

    // 3: clean press then release on key0
    i_key[0] = 1'b0;
    push("press0", 6'h01, 6'h00, 6'h00, accept_at(now));
    drain();
    check_bits("press0_state", o_key_state, 32'h3E);
    i_key[0] = 1'b1;
    push("release0", 6'h00, 6'h01, 6'h00, accept_at(now));
    drain();
    check_bits("release0_state", o_key_state, 32'h3F);

    // 4: auto-repeat on key1, release, then repeat timing restarts on re-press
    i_key[1] = 1'b0;
    p = accept_at(now);
    push("press1", 6'h02, 6'h00, 6'h00, p);
    for (int k = 0; k < 4; k++) push("repeat1", 6'h00, 6'h00, 6'h02, p + 50 + 20 * k);
    drain();
    i_key[1] = 1'b1;
    r = accept_at(now);
    for (int s = p + 130; s < r; s += 20) push("repeat1_tail", 6'h00, 6'h00, 6'h02, s);
    push("release1", 6'h00, 6'h02, 6'h00, r);
    drain();
    watch = '0;
    run_watch(60);
    check_bits("no_repeat_after_release", watch, 32'd0);
    i_key[1] = 1'b0;
    p = accept_at(now);
    push("press1b", 6'h02, 6'h00, 6'h00, p);
    push("repeat1b", 6'h00, 6'h00, 6'h02, p + 50);
    drain();
    i_key[1] = 1'b1;
    r = accept_at(now);
    for (int s = p + 70; s < r; s += 20) push("repeat1b_tail", 6'h00, 6'h00, 6'h02, s);
    push("release1b", 6'h00, 6'h02, 6'h00, r);
    drain();

    // 5: simultaneous press/release of keys 2 and 5
    i_key = 6'h1B;
    push("press25", 6'h24, 6'h00, 6'h00, accept_at(now));
    drain();
    check_bits("press25_state", o_key_state, 32'h1B);
    i_key = 6'h3F;
    push("release25", 6'h00, 6'h24, 6'h00, accept_at(now));
    drain();
    check_bits("release25_state", o_key_state, 32'h3F);

    // 6: reset during key3 repeat phase with key3 kept held
    i_key[3] = 1'b0;
    p = accept_at(now);
    push("press3", 6'h08, 6'h00, 6'h00, p);
    push("repeat3", 6'h00, 6'h00, 6'h08, p + 50);
    drain();
    repeat (4) step();
    i_rst = 1'b1;
    step();
    check_bits("midrst_state", o_key_state, 32'h3F);
    check_bits("midrst_pulses", {o_press, o_release, o_repeat}, 32'd0);
    check_bits("midrst_tick", o_tick, 32'd0);
    i_rst = 1'b0;
    t0 = now + 10;
    p = accept_at(now);
    push("press3_again", 6'h08, 6'h00, 6'h00, p);
    drain();
    check_bits("press3_again_state", o_key_state, 32'h37);
    i_key[3] = 1'b1;
    r = accept_at(now);
    for (int s = p + 50; s < r; s += 20) push("repeat3_tail", 6'h00, 6'h00, 6'h08, s);
    push("release3", 6'h00, 6'h08, 6'h00, r);
    drain();
    watch = '0;
    run_watch(30);
    check_bits("final_idle", watch, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at step %0d, required finish earlier", now);
    $fatal(1, "watchdog");
  end

endmodule
